host_cmd_issuer: RTL and testbench
==================================

Name: host_cmd_issuer

Overview:
- Initiator-side counterpart of host_cmd_port: takes one parallel command (r_w, engine enables, 9-bit length, 24-bit address) and serializes it as a 5-byte frame onto the shared 8-bit valid/ready command bus.
- Requests ownership of the bus before sending, then waits for the responder's acknowledgement on the ack bus before accepting the next command.
- Sits in the host/test-harness side of the memory-interface fabric, driving the bus that host_cmd_port consumes.

Parameters:
- ACK_ID, 2'd0: ack_bus_id value that completes this issuer's transaction.
- TIMEOUT_CYCLES, 1024: WAIT_ACK cycle limit. Used only when CMD_TIMEOUT_EN is defined.
- TO_W, 11: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can capture a command
- cmd_r_w  in  1  1=read, 0=write
- cmd_ena_fsm  in  1  enable transaction FSM path
- cmd_ena_qspi  in  1  enable QSPI path
- cmd_ena_status  in  1  enable status path
- cmd_length  in  9  transfer length
- cmd_address  in  24  byte address
- bus_req  out  1  request bus ownership
- bus_grant  in  1  ownership granted
- drive_bus  out  1  issuer owns and drives the bus
- out_bus_data  out  8  frame byte
- out_bus_valid  out  1  out_bus_data valid
- bus_ready  in  1  responder accepts byte
- ack_valid  in  1  ack bus strobe
- ack_id  in  2  ack bus id
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the matching ack is received
- timeout  out  1  one-cycle pulse on ack timeout (present only with CMD_TIMEOUT_EN)

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, cmd_ready=1, bus_req=0, drive_bus=0, out_bus_valid=0, out_bus_data=0, busy=0, done=0, timeout=0. Byte index=0 and the capture register=0.
- Frame byte order:
  - B0 = {r_w, ena_fsm, ena_qspi, ena_status, 3'b000, length[8]}
  - B1 = length[7:0]
  - B2 = address[23:16]
  - B3 = address[15:8]
  - B4 = address[7:0]
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register all command fields, go to REQ. cmd_ready=0 from the next cycle.
- REQ:
  - bus_req=1.
  - On bus_grant=1, go to SEND with index=0. drive_bus=1 and out_bus_valid=1 with B0 from the next cycle.
- SEND:
  - drive_bus=1, bus_req=1, out_bus_valid=1, out_bus_data=B[index].
  - A byte transfers when out_bus_valid&&bus_ready. Then index increments and the next byte appears in the following cycle.
  - No bubbles are inserted when bus_ready is held high, giving 5 consecutive transfer cycles.
  - While bus_ready=0, data and valid are held stable; valid never drops before the transfer.
  - bus_grant is sampled only in REQ. Ownership is kept until the frame ends, and deassertion of grant mid-frame is ignored.
  - After B4 transfers, go to WAIT_ACK. In that cycle bus_req, drive_bus and out_bus_valid go to 0.
- WAIT_ACK:
  - All bus outputs are 0.
  - On ack_valid&&ack_id==ACK_ID: pulse done=1 for one cycle and return to IDLE; cmd_ready=1 in that same cycle.
  - Acks with a non-matching id are ignored.
  - Acks during REQ or SEND are ignored; they are not queued.
- A length of 0 is legal and is transmitted unchanged.
- cmd_* inputs changing after capture have no effect.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). The frame is abandoned and is not resumed.
- Frame latency: command capture to first byte valid is 2 cycles when grant is already high.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no matching ack, pulse timeout=1 for one cycle, return to IDLE, done stays 0.
  - A matching ack in the same cycle as expiry wins: done=1, timeout=0.
- Undefined:
  - No counter and no timeout port. WAIT_ACK waits indefinitely.

Test Plan:
- Basic frame: r_w=1, fsm=1, qspi=0, status=1, length=9'h1A5, address=24'h123456; grant and ready held high. Bus must show 0xD1, 0xA5, 0x12, 0x34, 0x56 on 5 consecutive valid cycles. Ack id=ACK_ID then gives done for exactly 1 cycle and cmd_ready=1.
- Backpressure: same command, bus_ready=0 for 3 cycles while B2 is presented. out_bus_data must hold 0x12 with valid high throughout; the frame order is unchanged.
- Grant delay: bus_grant held low for 10 cycles. bus_req stays high, drive_bus=0 and no valid until grant. B0 must appear the cycle after grant.
- Ack filtering: ACK_ID=2, send ack_id=1 then ack_id=2. No done on the first; done on the second. An ack during SEND must produce no done.
- Reset mid-frame: assert rst_n=0 after B1 transfers. Outputs must reach reset values immediately. A new command with address 24'hABCDEF then sends from B0.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): send no ack. timeout must pulse exactly at the 16th WAIT_ACK cycle, done=0, then state is IDLE.

Source files
------------

// File: rtl/host_cmd_issuer.sv
// Initiator that serializes one parallel command into a 5-byte frame on the shared 8-bit command bus.
// Optional ack timeout is enabled by defining CMD_TIMEOUT_EN.
module host_cmd_issuer #(
    parameter logic [1:0]  ACK_ID         = 2'd0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_r_w,
    input  logic        cmd_ena_fsm,
    input  logic        cmd_ena_qspi,
    input  logic        cmd_ena_status,
    input  logic [8:0]  cmd_length,
    input  logic [23:0] cmd_address,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        drive_bus,
    output logic [7:0]  out_bus_data,
    output logic        out_bus_valid,
    input  logic        bus_ready,
    input  logic        ack_valid,
    input  logic [1:0]  ack_id,
    output logic        busy,
`ifdef CMD_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic        done
);

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = 4;

    typedef enum logic [1:0] {IDLE, REQ, SEND, WAIT_ACK} state_t;

    typedef struct packed {
        logic        r_w;
        logic        ena_fsm;
        logic        ena_qspi;
        logic        ena_status;
        logic [8:0]  length;
        logic [23:0] address;
    } cmd_t;

    // Reject a counter too narrow to reach the timeout terminal count.
    if (TIMEOUT_CYCLES == 0 || (TIMEOUT_CYCLES >> TO_W) != 0) begin : g_bad_cfg
        $error("host_cmd_issuer: TO_W too small for TIMEOUT_CYCLES");
    end

    state_t           state, state_nx;
    cmd_t             cmd_q, cmd_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [7:0]       data_nx;
    logic             done_nx;
    logic             transfer;
    logic             ack_hit;
`ifdef CMD_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;
    logic             timeout_nx;
`endif

    function automatic logic [7:0] frame_byte(input cmd_t c, input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    return {c.r_w, c.ena_fsm, c.ena_qspi, c.ena_status, 3'b000, c.length[8]};
            3'd1:    return c.length[7:0];
            3'd2:    return c.address[23:16];
            3'd3:    return c.address[15:8];
            default: return c.address[7:0];
        endcase
    endfunction

    assign transfer = out_bus_valid && bus_ready;
    assign ack_hit  = ack_valid && (ack_id == ACK_ID);

    // Next-state, capture and next-output decode.
    always_comb begin
        state_nx = state;
        cmd_nx   = cmd_q;
        idx_nx   = idx;
        data_nx  = out_bus_data;
        done_nx  = 1'b0;
`ifdef CMD_TIMEOUT_EN
        timeout_nx = 1'b0;
        to_cnt_nx  = (state == WAIT_ACK) ? TO_W'(to_cnt + 1'b1) : '0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_nx   = '{r_w: cmd_r_w, ena_fsm: cmd_ena_fsm, ena_qspi: cmd_ena_qspi,
                                 ena_status: cmd_ena_status, length: cmd_length,
                                 address: cmd_address};
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (bus_grant) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                    data_nx  = frame_byte(cmd_q, '0);
                end
            end
            SEND: begin
                if (transfer) begin
                    if (idx == IDX_W'(LAST_IDX)) begin
                        state_nx = WAIT_ACK;
                        idx_nx   = '0;
                        data_nx  = '0;
                    end else begin
                        idx_nx  = IDX_W'(idx + 1'b1);
                        data_nx = frame_byte(cmd_q, IDX_W'(idx + 1'b1));
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_hit) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
`ifdef CMD_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, capture and registered outputs; outputs track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd_q         <= '0;
            idx           <= '0;
            cmd_ready     <= 1'b1;
            bus_req       <= 1'b0;
            drive_bus     <= 1'b0;
            out_bus_valid <= 1'b0;
            out_bus_data  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt        <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            cmd_q         <= cmd_nx;
            idx           <= idx_nx;
            cmd_ready     <= (state_nx == IDLE);
            bus_req       <= (state_nx == REQ) || (state_nx == SEND);
            drive_bus     <= (state_nx == SEND);
            out_bus_valid <= (state_nx == SEND);
            out_bus_data  <= data_nx;
            busy          <= (state_nx != IDLE);
            done          <= done_nx;
`ifdef CMD_TIMEOUT_EN
            to_cnt        <= to_cnt_nx;
            timeout       <= timeout_nx;
`endif
        end
    end

endmodule

// File: tb/tb_host_cmd_issuer.sv
// Self-checking bench for host_cmd_issuer: directed scenarios plus randomized frames
// compared against byte lists computed arithmetically from each command.
module tb_host_cmd_issuer;

    localparam logic [1:0] ACK_ID = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic        cmd_r_w, cmd_ena_fsm, cmd_ena_qspi, cmd_ena_status;
    logic [8:0]  cmd_length;
    logic [23:0] cmd_address;
    logic        bus_req, bus_grant, drive_bus;
    logic [7:0]  out_bus_data;
    logic        out_bus_valid, bus_ready;
    logic        ack_valid;
    logic [1:0]  ack_id;
    logic        busy, done;
`ifdef CMD_TIMEOUT_EN
    logic        timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    host_cmd_issuer #(
        .ACK_ID(ACK_ID)
`ifdef CMD_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16), .TO_W(5)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_r_w(cmd_r_w), .cmd_ena_fsm(cmd_ena_fsm), .cmd_ena_qspi(cmd_ena_qspi),
        .cmd_ena_status(cmd_ena_status), .cmd_length(cmd_length), .cmd_address(cmd_address),
        .bus_req(bus_req), .bus_grant(bus_grant), .drive_bus(drive_bus),
        .out_bus_data(out_bus_data), .out_bus_valid(out_bus_valid), .bus_ready(bus_ready),
        .ack_valid(ack_valid), .ack_id(ack_id), .busy(busy),
`ifdef CMD_TIMEOUT_EN
        .timeout(timeout),
`endif
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_drive_bus"}, drive_bus, 0);
        check({tag, "_valid"}, out_bus_valid, 0);
        check({tag, "_data"}, out_bus_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef CMD_TIMEOUT_EN
        check({tag, "_timeout"}, timeout, 0);
`endif
    endtask

    // One command: g = grant delay cycles, stall bytes at stall_idx for stall_len cycles,
    // abort_after = reset once that many bytes moved (>=5 means no abort).
    task automatic run_frame(input logic rw, input logic f, input logic q, input logic s,
                             input logic [8:0] len, input logic [23:0] addr,
                             input int g, input int stall_idx, input int stall_len,
                             input int abort_after, input bit no_ack);
        logic [7:0] exp_b [5];
        int sent, k, stall_left, first, n;
        exp_b[0] = 8'(int'(rw) * 128 + int'(f) * 64 + int'(q) * 32 + int'(s) * 16 + int'(len) / 256);
        exp_b[1] = 8'(int'(len) % 256);
        exp_b[2] = 8'(int'(addr) / 65536);
        exp_b[3] = 8'((int'(addr) / 256) % 256);
        exp_b[4] = 8'(int'(addr) % 256);

        check("idle_cmd_ready", cmd_ready, 1);
        bus_grant = (g == 0); bus_ready = 1'b1; ack_valid = 1'b0;
        cmd_valid = 1'b1; cmd_r_w = rw; cmd_ena_fsm = f; cmd_ena_qspi = q; cmd_ena_status = s;
        cmd_length = len; cmd_address = addr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_r_w = 1'($urandom); cmd_ena_fsm = 1'($urandom); cmd_ena_qspi = 1'($urandom);
        cmd_ena_status = 1'($urandom); cmd_length = 9'($urandom); cmd_address = 24'($urandom);

        first = g + 2; sent = 0; k = 0; stall_left = stall_len;
        while (sent < 5 && k < 200) begin
            k++;
            if (k <= g) bus_grant = 1'b0;
            else if (k == g + 1) bus_grant = 1'b1;
            else bus_grant = 1'($urandom_range(0, 1));
            bus_ready = 1'b1;
            if (k >= first && sent == stall_idx && stall_left > 0) begin
                bus_ready = 1'b0;
                stall_left--;
            end
            ack_valid = ($urandom_range(0, 3) == 0);
            ack_id = ACK_ID;
            @(negedge clk);
            check("frame_done", done, 0);
            check("frame_cmd_ready", cmd_ready, 0);
            check("frame_busy", busy, 1);
            check("frame_bus_req", bus_req, 1);
            if (k < first) begin
                check("pre_grant_valid", out_bus_valid, 0);
                check("pre_grant_drive", drive_bus, 0);
            end else begin
                check("send_valid", out_bus_valid, 1);
                check("send_drive", drive_bus, 1);
                check("send_byte", out_bus_data, exp_b[sent]);
                if (bus_ready) sent++;
            end
            @(posedge clk); #1;
            if (sent == abort_after) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                @(posedge clk); #1;
                rst_n = 1'b1; ack_valid = 1'b0;
                return;
            end
        end
        check("frame_bytes", sent, 5);
        ack_valid = 1'b0;

        if (!no_ack) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                ack_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                ack_id = 2'(ACK_ID + 2'($urandom_range(1, 3)));
                @(negedge clk);
                check("wait_done", done, 0);
                check("wait_busy", busy, 1);
                check("wait_cmd_ready", cmd_ready, 0);
                check("wait_bus", {bus_req, drive_bus, out_bus_valid}, 0);
                check("wait_data", out_bus_data, 0);
                @(posedge clk); #1;
            end
            ack_valid = 1'b1; ack_id = ACK_ID;
            @(negedge clk);
            check("ack_cycle_done", done, 0);
            @(posedge clk); #1;
            ack_valid = 1'b0;
            @(negedge clk);
            check("ack_done", done, 1);
            check("ack_cmd_ready", cmd_ready, 1);
            check("ack_busy", busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", done, 0);
            @(posedge clk); #1;
        end
`ifdef CMD_TIMEOUT_EN
        else begin
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                check("to_wait_timeout", timeout, 0);
                check("to_wait_busy", busy, 1);
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("to_pulse", timeout, 1);
            check("to_done", done, 0);
            check("to_cmd_ready", cmd_ready, 1);
            check("to_busy", busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("to_one_cycle", timeout, 0);
            @(posedge clk); #1;
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_r_w = 1'b0; cmd_ena_fsm = 1'b0;
        cmd_ena_qspi = 1'b0; cmd_ena_status = 1'b0; cmd_length = '0; cmd_address = '0;
        bus_grant = 1'b0; bus_ready = 1'b0; ack_valid = 1'b0; ack_id = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1, 1, 0, 1, 9'h1A5, 24'h123456, 0, 9, 0, 99, 0);
        run_frame(1, 1, 0, 1, 9'h1A5, 24'h123456, 0, 2, 3, 99, 0);
        run_frame(0, 0, 1, 0, 9'h0F0, 24'h00FF00, 10, 9, 0, 99, 0);
        run_frame(1, 0, 1, 1, 9'h155, 24'h987654, 0, 9, 0, 2, 0);
        run_frame(0, 1, 1, 0, 9'h077, 24'hABCDEF, 0, 9, 0, 99, 0);
        run_frame(0, 0, 0, 0, 9'h000, 24'h000000, 1, 4, 2, 99, 0);
        run_frame(1, 1, 1, 1, 9'h1FF, 24'hFFFFFF, 0, 0, 1, 99, 0);

        repeat (25) begin
            run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      9'($urandom), 24'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 6), $urandom_range(0, 3), 99, 0);
        end
`ifdef CMD_TIMEOUT_EN
        run_frame(1, 0, 0, 1, 9'h021, 24'h112233, 0, 9, 0, 99, 1);
        run_frame(0, 1, 0, 0, 9'h042, 24'h445566, 0, 9, 0, 99, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
